sync_fifo_nw_1r: RTL and testbench

//  Single-clock FIFO with WR_LANES write lanes and one read port. Any subset of lanes
//  may push per cycle; enabled lanes are compacted into consecutive slots in ascending

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_lane_compactor.sv | 30 +++
 rtl/sync_fifo_nw_1r.sv | 125 ++++++++++++
 tb/tb_sync_fifo_nw_1r.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane FIFOs: lane popcount, depth derivation
// and lane-slice indexing.
package fifo_pkg;

  // Widest write-lane mask the helpers accept.
  localparam int LANE_MAX = 64;

  // Number of set bits in a lane mask (unused upper bits must be zero).
  function automatic int popcount(input logic [LANE_MAX-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < LANE_MAX; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

  // Storage depth from the address width.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // LSB position of lane 'lane' inside a flattened lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/fifo_lane_compactor.sv
// Turns a per-lane write-enable mask into per-lane slot offsets (exclusive
// prefix sum in ascending lane order) and the total number of enabled lanes.
// Purely combinational.
module fifo_lane_compactor
  import fifo_pkg::*;
#(
  parameter int WR_LANES = 2,
  parameter int OFF_W    = 4,
  parameter int CNT_W    = 5
) (
  input  logic [WR_LANES-1:0]            i_mask,
  output logic [WR_LANES-1:0][OFF_W-1:0] o_offset,
  output logic [CNT_W-1:0]               o_total
);

  // Each lane's offset counts the enabled lanes below it, so enabled lanes
  // land in consecutive slots with no gaps for disabled lanes.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc      = '0;
    o_offset = '0;
    for (int k = 0; k < WR_LANES; k++) begin
      o_offset[k] = acc[OFF_W-1:0];
      acc         = acc + {{(CNT_W-1){1'b0}}, i_mask[k]};
    end
  end

  assign o_total = CNT_W'(popcount(LANE_MAX'(i_mask)));

endmodule

// File: rtl/sync_fifo_nw_1r.sv
// Single-clock FIFO with WR_LANES compacting write lanes and one registered
// read port. Optional build macro FIFO_ALMOST_FULL_EN adds Almost_full_out.
module sync_fifo_nw_1r
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 4,
  parameter int WR_LANES      = 2
`ifdef FIFO_ALMOST_FULL_EN
  , parameter int ALMOST_FULL_THRESH = 12
`endif
) (
  input  logic                           Clk,
  input  logic                           Clear_in,
  input  logic                           stall,
  input  logic [WR_LANES*DATA_WIDTH-1:0] Data_in,
  input  logic [WR_LANES-1:0]            WriteEn_in,
  output logic                           Full_out,
  output logic                           Wr_reject_out,
  input  logic                           ReadEn_in,
  output logic [DATA_WIDTH-1:0]          Data_out,
  output logic                           Data_valid,
  output logic                           Empty_out,
  output logic [ADDRESS_WIDTH:0]         Count_out
`ifdef FIFO_ALMOST_FULL_EN
  , output logic                         Almost_full_out
`endif
);

  localparam int FIFO_DEPTH = fifo_depth(ADDRESS_WIDTH);
  localparam int CNT_W      = ADDRESS_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(WR_LANES);

  // Handshake: a push (any WriteEn_in lanes) is taken all-or-nothing on the
  // rising edge when !stall and the pre-edge free space covers every enabled
  // lane; otherwise it is refused and Wr_reject_out pulses one cycle later
  // (stalled requests are not refusals). A pop is taken when ReadEn_in &&
  // !Empty_out && !stall; the word appears on Data_out with Data_valid high in
  // the following cycle. A same-cycle pop never makes room for a push.

  logic [DATA_WIDTH-1:0]                 r_mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0]              r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0]              r_rd_ptr;
  logic [CNT_W-1:0]                      r_count;
  logic [DATA_WIDTH-1:0]                 r_data_out;
  logic                                  r_data_valid;
  logic                                  r_reject;

  logic [WR_LANES-1:0][ADDRESS_WIDTH-1:0] w_offset;
  logic [CNT_W-1:0]                       w_n;
  logic [CNT_W-1:0]                       w_free;
  logic                                   w_push_req;
  logic                                   w_push;
  logic                                   w_reject;
  logic                                   w_pop;
  logic [CNT_W-1:0]                       w_inc;
  logic [CNT_W-1:0]                       w_dec;

  fifo_lane_compactor #(
    .WR_LANES (WR_LANES),
    .OFF_W    (ADDRESS_WIDTH),
    .CNT_W    (CNT_W)
  ) u_compactor (
    .i_mask   (WriteEn_in),
    .o_offset (w_offset),
    .o_total  (w_n)
  );

  assign w_free     = DEPTH_C - r_count;
  assign w_push_req = !stall && (w_n != '0);
  assign w_push     = w_push_req && (w_n <= w_free);
  assign w_reject   = w_push_req && !w_push;
  assign w_pop      = ReadEn_in && (r_count != '0) && !stall;
  assign w_inc      = w_push ? w_n : '0;
  assign w_dec      = w_pop ? CNT_W'(1) : '0;

  // Storage write: j-th enabled lane goes to wr_ptr + j (wraps with the pointer).
  always_ff @(posedge Clk) begin
    for (int k = 0; k < WR_LANES; k++) begin
      if (w_push && WriteEn_in[k]) begin
        r_mem[r_wr_ptr + w_offset[k]] <= Data_in[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  // Pointers and the authoritative occupancy count.
  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + w_n[ADDRESS_WIDTH-1:0];
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDRESS_WIDTH'(1);
      r_count <= r_count + w_inc - w_dec;
    end
  end

  // Registered read port and reject pulse; Data_out holds when nothing pops.
  always_ff @(posedge Clk or posedge Clear_in) begin
    if (Clear_in) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_reject     <= 1'b0;
    end else begin
      if (w_pop) r_data_out <= r_mem[r_rd_ptr];
      r_data_valid <= w_pop;
      r_reject     <= w_reject;
    end
  end

  assign Data_out      = r_data_out;
  assign Data_valid    = r_data_valid;
  assign Wr_reject_out = r_reject;
  assign Count_out     = r_count;
  assign Empty_out     = (r_count == '0);
  // Full means a push on every lane could not fit; narrower pushes may still go in.
  assign Full_out      = (r_count > (DEPTH_C - LANES_C));

`ifdef FIFO_ALMOST_FULL_EN
  assign Almost_full_out = (r_count >= CNT_W'(ALMOST_FULL_THRESH));
`endif

endmodule

// File: tb/tb_sync_fifo_nw_1r.sv
// Directed bench for sync_fifo_nw_1r: a 2-lane depth-16 instance driven from a
// vector table plus hand sequences, and a 4-lane instance for lane compaction.
module tb_sync_fifo_nw_1r;

  localparam int DW = 65;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic            stall = 1'b0;
  logic [2*DW-1:0] d2 = '0;
  logic [1:0]      we2 = '0;
  logic            re2 = 1'b0;
  logic [DW-1:0]   dout2;
  logic            dv2, empty2, full2, rej2;
  logic [4:0]      cnt2;

  logic [4*DW-1:0] d4 = '0;
  logic [3:0]      we4 = '0;
  logic            re4 = 1'b0;
  logic [DW-1:0]   dout4;
  logic            dv4, empty4, full4, rej4;
  logic [4:0]      cnt4;
`ifdef FIFO_ALMOST_FULL_EN
  logic            af2, af4;
`endif

  sync_fifo_nw_1r #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(4), .WR_LANES(2)) u_dut2 (
    .Clk(clk), .Clear_in(clr), .stall(stall), .Data_in(d2), .WriteEn_in(we2),
    .Full_out(full2), .Wr_reject_out(rej2), .ReadEn_in(re2), .Data_out(dout2),
    .Data_valid(dv2), .Empty_out(empty2), .Count_out(cnt2)
`ifdef FIFO_ALMOST_FULL_EN
    , .Almost_full_out(af2)
`endif
  );

  sync_fifo_nw_1r #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(4), .WR_LANES(4)) u_dut4 (
    .Clk(clk), .Clear_in(clr), .stall(stall), .Data_in(d4), .WriteEn_in(we4),
    .Full_out(full4), .Wr_reject_out(rej4), .ReadEn_in(re4), .Data_out(dout4),
    .Data_valid(dv4), .Empty_out(empty4), .Count_out(cnt4)
`ifdef FIFO_ALMOST_FULL_EN
    , .Almost_full_out(af4)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step2(input logic [1:0] we, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic re, input logic st);
    @(negedge clk);
    we2 = we; d2 = {b, a}; re2 = re; stall = st;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [1:0]    we;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          re;
    logic          st;
    logic [4:0]    e_cnt;
    logic          e_empty;
    logic          e_full;
    logic          e_rej;
    logic          e_valid;
    logic [DW-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] we, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic re, input logic st, input logic [4:0] c, input logic em,
                              input logic fu, input logic rj, input logic va, input logic [DW-1:0] da);
    vec_t v;
    v.we = we; v.a = a; v.b = b; v.re = re; v.st = st;
    v.e_cnt = c; v.e_empty = em; v.e_full = fu; v.e_rej = rj; v.e_valid = va; v.e_data = da;
    return v;
  endfunction

  localparam int NV = 21;
  vec_t vecs [NV];
  int   n_pop;

  initial begin
    //          we     a      b      re st  cnt em fu rj va data
    vecs[0]  = mk(2'b00, 0,     0,     0, 0, 0,  1, 0, 0, 0, 0);
    vecs[1]  = mk(2'b01, 'h100, 0,     0, 0, 1,  0, 0, 0, 0, 0);
    vecs[2]  = mk(2'b11, 'h101, 'h102, 0, 0, 3,  0, 0, 0, 0, 0);
    vecs[3]  = mk(2'b10, 'h1EE, 'h103, 0, 0, 4,  0, 0, 0, 0, 0);
    vecs[4]  = mk(2'b00, 0,     0,     1, 0, 3,  0, 0, 0, 1, 'h100);
    vecs[5]  = mk(2'b01, 'h104, 0,     0, 0, 4,  0, 0, 0, 0, 'h100);
    vecs[6]  = mk(2'b01, 'h105, 0,     0, 0, 5,  0, 0, 0, 0, 'h100);
    vecs[7]  = mk(2'b11, 'h106, 'h107, 1, 0, 6,  0, 0, 0, 1, 'h101);
    vecs[8]  = mk(2'b11, 'h1E0, 'h1E1, 1, 1, 6,  0, 0, 0, 0, 'h101);
    vecs[9]  = mk(2'b00, 0,     0,     1, 0, 5,  0, 0, 0, 1, 'h102);
    vecs[10] = mk(2'b00, 0,     0,     0, 0, 5,  0, 0, 0, 0, 'h102);
    vecs[11] = mk(2'b11, 'h108, 'h109, 0, 0, 7,  0, 0, 0, 0, 'h102);
    vecs[12] = mk(2'b11, 'h10A, 'h10B, 0, 0, 9,  0, 0, 0, 0, 'h102);
    vecs[13] = mk(2'b11, 'h10C, 'h10D, 0, 0, 11, 0, 0, 0, 0, 'h102);
    vecs[14] = mk(2'b11, 'h10E, 'h10F, 0, 0, 13, 0, 0, 0, 0, 'h102);
    vecs[15] = mk(2'b11, 'h110, 'h111, 0, 0, 15, 0, 1, 0, 0, 'h102);
    vecs[16] = mk(2'b11, 'h1F0, 'h1F1, 0, 0, 15, 0, 1, 1, 0, 'h102);
    vecs[17] = mk(2'b01, 'h112, 0,     0, 0, 16, 0, 1, 0, 0, 'h102);
    vecs[18] = mk(2'b01, 'h1F2, 0,     0, 0, 16, 0, 1, 1, 0, 'h102);
    vecs[19] = mk(2'b01, 'h1F3, 0,     1, 0, 15, 0, 1, 1, 1, 'h103);
    vecs[20] = mk(2'b00, 0,     0,     1, 0, 14, 0, 0, 0, 1, 'h104);

    // Reset state while Clear_in is held.
    #12;
    check("rst count", DW'(cnt2), 0);
    check("rst empty", DW'(empty2), 1);
    check("rst full", DW'(full2), 0);
    check("rst valid", DW'(dv2), 0);
    check("rst reject", DW'(rej2), 0);
    @(negedge clk);
    clr = 1'b0;

    // Table: push/pop, compaction, stall, full/reject, no same-cycle credit.
    for (int i = 0; i < NV; i++) begin
      step2(vecs[i].we, vecs[i].a, vecs[i].b, vecs[i].re, vecs[i].st);
      check($sformatf("v%0d count", i), DW'(cnt2), DW'(vecs[i].e_cnt));
      check($sformatf("v%0d empty", i), DW'(empty2), DW'(vecs[i].e_empty));
      check($sformatf("v%0d full", i), DW'(full2), DW'(vecs[i].e_full));
      check($sformatf("v%0d reject", i), DW'(rej2), DW'(vecs[i].e_rej));
      check($sformatf("v%0d valid", i), DW'(dv2), DW'(vecs[i].e_valid));
      check($sformatf("v%0d data", i), dout2, vecs[i].e_data);
    end

    // Drain the remaining 14 entries in order.
    for (int i = 0; i < 14; i++) begin
      step2(2'b00, 0, 0, 1, 0);
      check($sformatf("drain%0d valid", i), DW'(dv2), 1);
      check($sformatf("drain%0d data", i), dout2, DW'('h105 + i));
    end
    check("drain empty", DW'(empty2), 1);

    // Underflow: pop on empty is ignored.
    step2(2'b00, 0, 0, 1, 0);
    check("underflow valid", DW'(dv2), 0);
    check("underflow count", DW'(cnt2), 0);

    // Wrap: 40 single pushes through the depth-16 FIFO, scoreboard ordered.
    n_pop = 0;
    for (int i = 0; i < 40; i++) begin
      step2(2'b01, DW'(i), 0, (i >= 8), 0);
      exp_q.push_back(DW'(i));
      if (dv2) begin
        n_pop++;
        check($sformatf("wrap pop%0d", n_pop), dout2, exp_q.pop_front());
      end
    end
    for (int i = 0; i < 8; i++) begin
      step2(2'b00, 0, 0, 1, 0);
      if (dv2) begin
        n_pop++;
        check($sformatf("wrap pop%0d", n_pop), dout2, exp_q.pop_front());
      end
    end
    check("wrap pop total", DW'(n_pop), 40);
    check("wrap empty", DW'(empty2), 1);

    // Mid-cycle reset discards contents; first edge after release accepts a push.
    step2(2'b11, 'h200, 'h201, 0, 0);
    step2(2'b01, 'h202, 0, 1, 0);
    check("pre-clr count", DW'(cnt2), 2);
    #2;
    clr = 1'b1;
    #1;
    check("clr count", DW'(cnt2), 0);
    check("clr empty", DW'(empty2), 1);
    check("clr valid", DW'(dv2), 0);
    check("clr full", DW'(full2), 0);
    check("clr data", dout2, 0);
    clr = 1'b0;
    step2(2'b01, 'h300, 0, 0, 0);
    check("post-clr count", DW'(cnt2), 1);
    step2(2'b00, 0, 0, 1, 0);
    check("post-clr data", dout2, 'h300);
    check("post-clr valid", DW'(dv2), 1);
    check("post-clr empty", DW'(empty2), 1);

    // Four-lane compaction: lanes 1 and 3 land in consecutive slots.
    @(negedge clk);
    we2 = '0; re2 = 1'b0;
    we4 = 4'b1010;
    d4  = '0;
    d4[1*DW +: DW] = 'hA;
    d4[3*DW +: DW] = 'hB;
    @(posedge clk);
    #1;
    check("c4 count2", DW'(cnt4), 2);
    @(negedge clk);
    we4 = '0; re4 = 1'b1;
    @(posedge clk);
    #1;
    check("c4 pop0", dout4, 'hA);
    check("c4 count1", DW'(cnt4), 1);
    @(posedge clk);
    #1;
    check("c4 pop1", dout4, 'hB);
    check("c4 count0", DW'(cnt4), 0);
    @(negedge clk);
    re4 = 1'b0;

`ifdef FIFO_ALMOST_FULL_EN
    // Almost-full threshold 12.
    for (int i = 0; i < 5; i++) step2(2'b11, DW'(2*i), DW'(2*i+1), 0, 0);
    step2(2'b01, 'h10, 0, 0, 0);
    check("af count11", DW'(cnt2), 11);
    check("af at 11", DW'(af2), 0);
    step2(2'b01, 'h11, 0, 0, 0);
    check("af count12", DW'(cnt2), 12);
    check("af at 12", DW'(af2), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
